// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared display definitions: glyph table, line polarities, frame sizing.
// The scan encoder uses the same table, so both ends agree on every glyph.
package seven_segment_scan_decoder_pkg;

  // Segment and digit-strobe lines are driven low to light or select.
  localparam logic seg_active_low   = 1'b1;
  localparam logic digit_active_low = 1'b1;

  // Glyphs in active-high abcdefg order, with segment a as the MSB.
  localparam logic [6:0] glyph_0 = 7'b1111110;
  localparam logic [6:0] glyph_1 = 7'b0110000;
  localparam logic [6:0] glyph_2 = 7'b1101101;
  localparam logic [6:0] glyph_3 = 7'b1111001;
  localparam logic [6:0] glyph_4 = 7'b0110011;
  localparam logic [6:0] glyph_5 = 7'b1011011;
  localparam logic [6:0] glyph_6 = 7'b1011111;
  localparam logic [6:0] glyph_7 = 7'b1110000;
  localparam logic [6:0] glyph_8 = 7'b1111111;
  localparam logic [6:0] glyph_9 = 7'b1111011;
  localparam logic [6:0] glyph_a = 7'b1110111;
  localparam logic [6:0] glyph_b = 7'b0011111;
  localparam logic [6:0] glyph_c = 7'b1001110;
  localparam logic [6:0] glyph_d = 7'b0111101;
  localparam logic [6:0] glyph_e = 7'b1001111;
  localparam logic [6:0] glyph_f = 7'b1000111;

  localparam logic [6:0] glyph_tbl [16] = '{
    glyph_0, glyph_1, glyph_2, glyph_3, glyph_4, glyph_5, glyph_6, glyph_7,
    glyph_8, glyph_9, glyph_a, glyph_b, glyph_c, glyph_d, glyph_e, glyph_f
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       unknown;
  } glyph_t;

  // Width of the packed hex field for a display of n digits.
  function automatic int frame_width(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/seven_segment_scan_decoder_if.sv
// Scan input and frame output bundle of the scan decoder.
// master: the decoder (consumes the scan, produces frames).
// slave:  the scan driver / frame consumer.
interface seven_segment_scan_decoder_if
  import seven_segment_scan_decoder_pkg::*;
#(
  parameter int w_digit = 4
);
  logic [7:0]                      abcdefgh;
  logic [w_digit-1:0]              digit;
  logic                            out_valid;
  logic                            out_ready;
  logic [frame_width(w_digit)-1:0] out_hex;
  logic [w_digit-1:0]              out_dot;
  logic [w_digit-1:0]              out_unknown;
  logic                            overflow;
  logic                            multi_digit_error;

  modport master (
    input  abcdefgh, digit, out_ready,
    output out_valid, out_hex, out_dot, out_unknown, overflow, multi_digit_error
  );

  modport slave (
    output abcdefgh, digit, out_ready,
    input  out_valid, out_hex, out_dot, out_unknown, overflow, multi_digit_error
  );
endinterface

// File: rtl/seven_segment_glyph_decoder.sv
// Maps an active-high abcdefg pattern to its hex nibble; anything that is
// not one of the sixteen glyphs (all-off included) decodes as unknown/0.
module seven_segment_glyph_decoder
  import seven_segment_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output glyph_t     glyph
);

  // Table lookup; the glyphs are unique so at most one entry matches.
  always_comb begin
    glyph.nibble  = 4'd0;
    glyph.unknown = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == glyph_tbl[i]) begin
        glyph.nibble  = 4'(i);
        glyph.unknown = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Reconstructs the displayed hex frame from a multiplexed seven-segment
// scan: samples the lines, waits for a settled dwell, decodes the strobed
// digit, and hands out one frame per complete scan on valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | no frame pending, out_valid = 0
// HOLD    | frame presented, out_valid = 1, fields frozen until taken
module seven_segment_scan_decoder
  import seven_segment_scan_decoder_pkg::*;
#(
  parameter int w_digit       = 4,
  parameter int settle_cycles = 2
)(
  input  logic                        clk,
  input  logic                        reset,
  seven_segment_scan_decoder_if.master bus
);

  localparam int w_sample = 8 + w_digit;
  localparam int w_frame  = frame_width(w_digit);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [w_sample-1:0] sample_in;
  logic [w_sample-1:0] s_reg;
  logic [7:0]          cnt;
  logic                dwell_taken;
  logic [w_digit-1:0]  digit_low;
  logic [6:0]          seg_on;
  logic                dot_on;
  glyph_t              glyph;
  logic                settled;
  logic                accept;
  logic                multi_low;
  logic                frame_done;
  logic                xfer;

  logic [w_digit-1:0]  seen;
  logic [w_frame-1:0]  work_hex, work_hex_nx;
  logic [w_digit-1:0]  work_dot, work_dot_nx;
  logic [w_digit-1:0]  work_unk, work_unk_nx;

  logic [0:0]          state;
  logic [w_frame-1:0]  hex_q;
  logic [w_digit-1:0]  dot_q;
  logic [w_digit-1:0]  unk_q;
  logic                overflow_q;
  logic                multi_q;

  assign sample_in = {bus.abcdefgh, bus.digit};
  assign digit_low = s_reg[w_digit-1:0] ^ {w_digit{digit_active_low}};
  assign seg_on    = s_reg[w_sample-1 -: 7] ^ {7{seg_active_low}};
  assign dot_on    = s_reg[w_digit] ^ seg_active_low;

  seven_segment_glyph_decoder u_glyph (
    .seg   (seg_on),
    .glyph (glyph)
  );

  assign settled    = (cnt == 8'(settle_cycles));
  assign multi_low  = ($countones(digit_low) > 1);
  assign accept     = settled && ($countones(digit_low) == 1) && !dwell_taken;
  assign frame_done = accept && ((seen | digit_low) == '1);
  assign xfer       = (state == HOLD) && bus.out_ready;

  // Working copy with the currently strobed digit merged in.
  always_comb begin
    work_hex_nx = work_hex;
    work_dot_nx = work_dot;
    work_unk_nx = work_unk;
    for (int i = 0; i < w_digit; i++) begin
      if (digit_low[i]) begin
        work_hex_nx[4*i +: 4] = glyph.nibble;
        work_dot_nx[i]        = dot_on;
        work_unk_nx[i]        = glyph.unknown;
      end
    end
  end

  // Input register and stability counter; a change starts a new dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_reg       <= '1;
      cnt         <= 8'd0;
      dwell_taken <= 1'b0;
    end else begin
      s_reg <= sample_in;
      if (sample_in != s_reg) begin
        cnt         <= 8'd1;
        dwell_taken <= 1'b0;
      end else begin
        if (cnt != 8'(settle_cycles))
          cnt <= cnt + 8'd1;
        if (accept)
          dwell_taken <= 1'b1;
      end
    end
  end

  // Working registers and seen mask; latest acceptance of a digit wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen     <= '0;
      work_hex <= '0;
      work_dot <= '0;
      work_unk <= '0;
    end else if (accept) begin
      work_hex <= work_hex_nx;
      work_dot <= work_dot_nx;
      work_unk <= work_unk_nx;
      seen     <= frame_done ? '0 : (seen | digit_low);
    end
  end

  // Frame handoff FSM plus sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      hex_q      <= '0;
      dot_q      <= '0;
      unk_q      <= '0;
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      if (settled && multi_low)
        multi_q <= 1'b1;
      if (frame_done) begin
        if ((state == COLLECT) || bus.out_ready) begin
          hex_q <= work_hex_nx;
          dot_q <= work_dot_nx;
          unk_q <= work_unk_nx;
          state <= HOLD;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (xfer) begin
        state <= COLLECT;
      end
    end
  end

  assign bus.out_valid         = (state == HOLD);
  assign bus.out_hex           = hex_q;
  assign bus.out_dot           = dot_q;
  assign bus.out_unknown       = unk_q;
  assign bus.overflow          = overflow_q;
  assign bus.multi_digit_error = multi_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for the scan decoder: a table of full scans with
// hand-computed frames, followed by glitch, stall/overflow, multi-strobe
// and mid-frame reset sequences.
module tb_seven_segment_scan_decoder;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  seven_segment_scan_decoder_if #(.w_digit(4)) bus ();

  seven_segment_scan_decoder #(.w_digit(4), .settle_cycles(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes mid-cycle, where valid/ready are stable.
  always @(negedge clk) if (bus.out_valid && bus.out_ready) xfers++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Independent glyph table, active-high abcdefg, a = MSB.
  logic [6:0] tg [16];

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dots;
    logic [15:0] exp_hex;
    logic [3:0]  exp_dot;
    logic [3:0]  exp_unk;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.abcdefgh = 8'hFF;
    bus.digit    = 4'hF;
    tick(n);
  endtask

  task automatic show(input int idx, input logic [6:0] seg, input logic dp, input int hold);
    bus.abcdefgh = ~{seg, dp};
    bus.digit    = ~(4'(1 << idx));
    tick(hold);
  endtask

  task automatic scan_frame(input logic [27:0] segs, input logic [3:0] dots);
    for (int d = 3; d >= 0; d--) show(d, segs[7*d +: 7], dots[d], 3);
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] hx,
                              input logic [3:0] dt, input logic [3:0] uk);
    int n;
    n = 0;
    while (!bus.out_valid && n < 8) begin
      tick(1);
      n++;
    end
    check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " hex"}, 32'(bus.out_hex), 32'(hx));
    check({tag, " dot"}, 32'(bus.out_dot), 32'(dt));
    check({tag, " unknown"}, 32'(bus.out_unknown), 32'(uk));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " hex"}, 32'(bus.out_hex), 32'd0);
    check({tag, " dot"}, 32'(bus.out_dot), 32'd0);
    check({tag, " unknown"}, 32'(bus.out_unknown), 32'd0);
    check({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, " multi"}, 32'(bus.multi_digit_error), 32'd0);
  endtask

  initial begin
    int base;

    tg[0]  = 7'b1111110; tg[1]  = 7'b0110000; tg[2]  = 7'b1101101; tg[3]  = 7'b1111001;
    tg[4]  = 7'b0110011; tg[5]  = 7'b1011011; tg[6]  = 7'b1011111; tg[7]  = 7'b1110000;
    tg[8]  = 7'b1111111; tg[9]  = 7'b1111011; tg[10] = 7'b1110111; tg[11] = 7'b0011111;
    tg[12] = 7'b1001110; tg[13] = 7'b0111101; tg[14] = 7'b1001111; tg[15] = 7'b1000111;

    // segs packs digit 3..0 from left to right.
    vecs[0] = '{{tg[4], tg[3], tg[2], tg[1]}, 4'b0000, 16'h4321, 4'b0000, 4'b0000};
    vecs[1] = '{{tg[10], tg[11], tg[12], tg[13]}, 4'b0010, 16'hABCD, 4'b0010, 4'b0000};
    vecs[2] = '{{tg[14], tg[15], tg[0], tg[9]}, 4'b1111, 16'hEF09, 4'b1111, 4'b0000};
    vecs[3] = '{{tg[5], 7'b1010101, tg[7], tg[8]}, 4'b0010, 16'h5078, 4'b0010, 4'b0100};
    vecs[4] = '{{tg[1], tg[2], tg[3], 7'b0000000}, 4'b0000, 16'h1230, 4'b0000, 4'b0001};

    reset        = 1'b1;
    bus.abcdefgh = 8'hFF;
    bus.digit    = 4'hF;
    bus.out_ready = 1'b1;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(3);

    // Table of complete scans, consumer always ready.
    for (int v = 0; v < 5; v++) begin
      base = xfers;
      scan_frame(vecs[v].segs, vecs[v].dots);
      expect_frame($sformatf("vec%0d", v), vecs[v].exp_hex, vecs[v].exp_dot, vecs[v].exp_unk);
      idle(3);
      check($sformatf("vec%0d xfers", v), 32'(xfers - base), 32'd1);
    end

    // One-cycle all-on glitch on digit 0 between dwells must be ignored.
    base = xfers;
    show(3, tg[9], 1'b0, 3);
    show(2, tg[8], 1'b0, 3);
    show(1, tg[7], 1'b0, 3);
    bus.abcdefgh = 8'h00;
    bus.digit    = 4'b1110;
    tick(1);
    check("glitch no valid", 32'(bus.out_valid), 32'd0);
    show(0, tg[6], 1'b0, 3);
    expect_frame("glitch", 16'h9876, 4'b0000, 4'b0000);
    idle(3);
    check("glitch xfers", 32'(xfers - base), 32'd1);

    // Stall across two scans: first frame held, second dropped.
    bus.out_ready = 1'b0;
    base = xfers;
    scan_frame({tg[1], tg[2], tg[3], tg[4]}, 4'b0000);
    expect_frame("stall first", 16'h1234, 4'b0000, 4'b0000);
    check("stall no overflow yet", 32'(bus.overflow), 32'd0);
    scan_frame({tg[5], tg[6], tg[7], tg[8]}, 4'b1111);
    check("stall overflow", 32'(bus.overflow), 32'd1);
    check("stall valid held", 32'(bus.out_valid), 32'd1);
    check("stall hex held", 32'(bus.out_hex), 32'h1234);
    check("stall dot held", 32'(bus.out_dot), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("stall valid before take", 32'(bus.out_valid), 32'd1);
    tick(1);
    check("stall valid after take", 32'(bus.out_valid), 32'd0);
    idle(3);
    check("stall xfers", 32'(xfers - base), 32'd1);
    check("overflow sticky", 32'(bus.overflow), 32'd1);

    // Two strobes low: flag error, accept nothing, keep seen intact.
    base = xfers;
    show(1, tg[5], 1'b0, 3);
    show(0, tg[4], 1'b0, 3);
    check("multi pre flag", 32'(bus.multi_digit_error), 32'd0);
    bus.abcdefgh = ~{tg[8], 1'b0};
    bus.digit    = 4'b1100;
    tick(3);
    check("multi flag", 32'(bus.multi_digit_error), 32'd1);
    check("multi no valid", 32'(bus.out_valid), 32'd0);
    show(3, tg[7], 1'b0, 3);
    show(2, tg[6], 1'b0, 3);
    expect_frame("multi", 16'h7654, 4'b0000, 4'b0000);
    idle(3);
    check("multi xfers", 32'(xfers - base), 32'd1);

    // Reset after two digits accepted: everything clears, seen included.
    show(1, tg[9], 1'b1, 3);
    show(0, tg[8], 1'b1, 3);
    reset = 1'b1;
    #2;
    check_all_zero("midreset");
    idle(2);
    reset = 1'b0;
    idle(2);
    base = xfers;
    show(3, tg[1], 1'b0, 3);
    show(2, tg[2], 1'b0, 3);
    show(1, tg[3], 1'b0, 3);
    check("midreset no early frame", 32'(bus.out_valid), 32'd0);
    check("midreset no early xfer", 32'(xfers - base), 32'd0);
    show(0, tg[4], 1'b0, 3);
    expect_frame("midreset", 16'h1234, 4'b0000, 4'b0000);
    idle(3);
    check("midreset xfers", 32'(xfers - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
